ser_frame_sched: RTL and testbench

Round-robin scheduler that shares one LSB-first parallel-to-serial shifter between several byte producers. It arbitrates requests, captures the winning byte, and shifts it out one bit per clock. It then inserts an idle gap so the downstream Moore sequence detector sees cleanly separated frames. It sits between the byte sources and the serial detector input.

---
 rtl/ser_frame_sched_pkg.sv | 37 +++
 rtl/ser_frame_sched_arb.sv | 32 +++
 rtl/ser_frame_sched.sv | 177 +++++++++++++++++
 tb/tb_ser_frame_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_frame_sched_pkg.sv
// Shared types and helpers for the serial frame scheduler.
// Optional build feature: SER_PARITY_EN appends an odd-parity bit to each frame.
package ser_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

`ifdef SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Frame length for the default byte width; frame_len() covers other widths.
  localparam int DEF_DW    = 8;
  localparam int FRAME_LEN = DEF_DW + PAR_BITS;

  function automatic int frame_len(input int dw);
    return dw + PAR_BITS;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Odd parity bit: makes the total count of ones (data + parity) odd.
  // Zero-extension of narrower data does not change the result.
  function automatic logic odd_par(input logic [31:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ser_frame_sched_arb.sv
// Combinational round-robin winner selection: first set request at or above
// the pointer, wrapping. The pointer register lives in the parent.
module rr_arbiter
  import ser_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int SW   = cnt_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SW-1:0]    ptr,
  output logic [SW-1:0]    winner,
  output logic             any
);

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    winner = {SW{1'b0}};
    any    = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) begin
        winner = SW'(idx);
        any    = 1'b1;
      end else begin
        winner = winner;
        any    = any;
      end
    end
  end

endmodule

// File: rtl/ser_frame_sched.sv
// Round-robin scheduler sharing one LSB-first serializer between N_REQ byte
// producers, with GAP idle cycles between frames.
// Optional build feature: SER_PARITY_EN (odd parity bit after the data bits).
module ser_frame_sched
  import ser_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int GAP   = 1,
  localparam int SW   = cnt_w(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    ack,
  output logic                dout,
  output logic                dvalid,
  output logic                sof,
  output logic [SW-1:0]       src,
  output logic                busy
);

  localparam int CW = cnt_w(DW);

  state_t            state_r, state_s;
  logic [SW-1:0]     ptr_r, ptr_s;
  logic [DW-1:0]     shreg_r, shreg_s;
  logic [CW-1:0]     bcnt_r, bcnt_s;
  logic [3:0]        gcnt_r, gcnt_s;
  logic              par_r, par_s;
  logic [SW-1:0]     src_r, src_s;
  logic [N_REQ-1:0]  ack_r, ack_s;
  logic              dout_r, dout_s;
  logic              dvalid_r, dvalid_s;
  logic              sof_r, sof_s;
  logic              busy_r, busy_s;
  logic              decide_s, frame_end_s;
  logic [SW-1:0]     winner_s;
  logic              any_s;
  logic [DW-1:0]     win_byte_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  assign win_byte_s = din[winner_s*DW +: DW];

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    shreg_s     = shreg_r;
    bcnt_s      = bcnt_r;
    gcnt_s      = gcnt_r;
    par_s       = par_r;
    src_s       = src_r;
    ack_s       = {N_REQ{1'b0}};
    dout_s      = dout_r;
    dvalid_s    = dvalid_r;
    sof_s       = 1'b0;
    busy_s      = busy_r;
    decide_s    = 1'b0;
    frame_end_s = 1'b0;

    case (state_r)
      ST_IDLE: decide_s = 1'b1;
      ST_SHIFT: begin
        if (bcnt_r != CW'(DW - 1)) begin
          bcnt_s  = bcnt_r + CW'(1);
          shreg_s = shreg_r >> 1;
          dout_s  = shreg_r[1];
        end else begin
`ifdef SER_PARITY_EN
          state_s = ST_PAR;
          dout_s  = par_r;
`else
          frame_end_s = 1'b1;
`endif
        end
      end
      ST_PAR: frame_end_s = 1'b1;
      ST_GAP: begin
        if (gcnt_r == 4'(GAP - 1)) begin
          decide_s = 1'b1;
        end else begin
          gcnt_s = gcnt_r + 4'd1;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    // Last data/parity bit done: either idle gap or straight to a decision.
    if (frame_end_s) begin
      if (GAP > 0) begin
        state_s  = ST_GAP;
        gcnt_s   = 4'd0;
        dout_s   = 1'b0;
        dvalid_s = 1'b0;
      end else begin
        decide_s = 1'b1;
      end
    end else begin
      decide_s = decide_s;
    end

    // Decision edge: grant the round-robin winner or fall back to idle.
    if (decide_s) begin
      if (any_s) begin
        state_s          = ST_SHIFT;
        shreg_s          = win_byte_s;
        bcnt_s           = {CW{1'b0}};
        par_s            = odd_par(32'(win_byte_s));
        src_s            = winner_s;
        ack_s[winner_s]  = 1'b1;
        dout_s           = win_byte_s[0];
        dvalid_s         = 1'b1;
        sof_s            = 1'b1;
        busy_s           = 1'b1;
        if (winner_s == SW'(N_REQ - 1)) begin
          ptr_s = {SW{1'b0}};
        end else begin
          ptr_s = winner_s + SW'(1);
        end
      end else begin
        state_s  = ST_IDLE;
        dout_s   = 1'b0;
        dvalid_s = 1'b0;
        busy_s   = 1'b0;
      end
    end else begin
      busy_s = busy_r;
    end
  end

  // State and registered-output update; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ptr_r    <= {SW{1'b0}};
      shreg_r  <= {DW{1'b0}};
      bcnt_r   <= {CW{1'b0}};
      gcnt_r   <= 4'd0;
      par_r    <= 1'b0;
      src_r    <= {SW{1'b0}};
      ack_r    <= {N_REQ{1'b0}};
      dout_r   <= 1'b0;
      dvalid_r <= 1'b0;
      sof_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      shreg_r  <= shreg_s;
      bcnt_r   <= bcnt_s;
      gcnt_r   <= gcnt_s;
      par_r    <= par_s;
      src_r    <= src_s;
      ack_r    <= ack_s;
      dout_r   <= dout_s;
      dvalid_r <= dvalid_s;
      sof_r    <= sof_s;
      busy_r   <= busy_s;
    end
  end

  assign ack    = ack_r;
  assign dout   = dout_r;
  assign dvalid = dvalid_r;
  assign sof    = sof_r;
  assign src    = src_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_ser_frame_sched.sv
// Bench for ser_frame_sched: two instances (GAP=1 and GAP=0) driven by
// producers, each compared cycle by cycle with a queue-based frame model.
module tb_ser_frame_sched;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int GAPV [2] = '{1, 0};

  typedef struct {
    logic         dout;
    logic         dvalid;
    logic         sof;
    logic         busy;
    logic [N-1:0] ack;
    logic [1:0]   src;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_a    [2];
  logic [N*DW-1:0]  din_a    [2];
  logic [N-1:0]     ack_a    [2];
  logic             dout_a   [2];
  logic             dvalid_a [2];
  logic             sof_a    [2];
  logic [1:0]       src_a    [2];
  logic             busy_a   [2];

  exp_t       q   [2][$];
  exp_t       cur [2];
  logic [1:0] m_ptr [2];
  logic [1:0] m_src [2];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ser_frame_sched #(.N_REQ(N), .DW(DW), .GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .req(req_a[0]), .din(din_a[0]), .ack(ack_a[0]),
    .dout(dout_a[0]), .dvalid(dvalid_a[0]), .sof(sof_a[0]), .src(src_a[0]),
    .busy(busy_a[0]));

  ser_frame_sched #(.N_REQ(N), .DW(DW), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .req(req_a[1]), .din(din_a[1]), .ack(ack_a[1]),
    .dout(dout_a[1]), .dvalid(dvalid_a[1]), .sof(sof_a[1]), .src(src_a[1]),
    .busy(busy_a[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      m_ptr[k] = 2'd0;
      m_src[k] = 2'd0;
    end
  endtask

  // At an empty queue the scheduler decides: enqueue a whole frame or one idle cycle.
  task automatic model_step(input int k);
    exp_t e;
    if (q[k].size() == 0) begin
      if (req_a[k] != '0) begin
        int w;
        logic [DW-1:0] b;
        w = -1;
        for (int j = 0; j < N; j++) begin
          int idx;
          idx = (int'(m_ptr[k]) + j) % N;
          if (w < 0 && req_a[k][idx]) w = idx;
        end
        b = din_a[k][w*DW +: DW];
        m_src[k] = 2'(w);
        m_ptr[k] = 2'((w + 1) % N);
        for (int i = 0; i < DW; i++) begin
          e.dout = b[i]; e.dvalid = 1'b1; e.sof = (i == 0); e.busy = 1'b1;
          e.ack = (i == 0) ? N'(1 << w) : '0; e.src = m_src[k];
          q[k].push_back(e);
        end
        if (P == 1) begin
          e.dout = ($countones(b) % 2 == 0); e.dvalid = 1'b1; e.sof = 1'b0;
          e.busy = 1'b1; e.ack = '0; e.src = m_src[k];
          q[k].push_back(e);
        end
        for (int g = 0; g < GAPV[k]; g++) begin
          e.dout = 1'b0; e.dvalid = 1'b0; e.sof = 1'b0; e.busy = 1'b1;
          e.ack = '0; e.src = m_src[k];
          q[k].push_back(e);
        end
      end else begin
        e.dout = 1'b0; e.dvalid = 1'b0; e.sof = 1'b0; e.busy = 1'b0;
        e.ack = '0; e.src = m_src[k];
        q[k].push_back(e);
      end
    end
    cur[k] = q[k].pop_front();
  endtask

  task automatic check_outputs(input int k, input exp_t e);
    check($sformatf("ack%0d", k),    32'(ack_a[k]),    32'(e.ack));
    check($sformatf("dout%0d", k),   32'(dout_a[k]),   32'(e.dout));
    check($sformatf("dvalid%0d", k), 32'(dvalid_a[k]), 32'(e.dvalid));
    check($sformatf("sof%0d", k),    32'(sof_a[k]),    32'(e.sof));
    check($sformatf("src%0d", k),    32'(src_a[k]),    32'(e.src));
    check($sformatf("busy%0d", k),   32'(busy_a[k]),   32'(e.busy));
  endtask

  // mode 0: drop req on ack; 1: keep req with fresh data; 2: random producers
  task automatic run_cycles(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check_outputs(k, cur[k]);
        for (int i = 0; i < N; i++) begin
          if (cur[k].ack[i]) begin
            if (mode == 0) begin
              req_a[k][i] = 1'b0;
            end else if (mode == 1) begin
              din_a[k][i*DW +: DW] = 8'($urandom);
            end else begin
              req_a[k][i] = 1'($urandom_range(0, 1));
              din_a[k][i*DW +: DW] = 8'($urandom);
            end
          end else if (mode == 2) begin
            if (!req_a[k][i]) begin
              if ($urandom_range(0, 3) == 0) begin
                req_a[k][i] = 1'b1;
                din_a[k][i*DW +: DW] = 8'($urandom);
              end
            end else if ($urandom_range(0, 49) == 0) begin
              req_a[k][i] = 1'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic set_both(input logic [N-1:0] r, input logic [N*DW-1:0] d);
    for (int k = 0; k < 2; k++) begin
      req_a[k] = r;
      din_a[k] = d;
    end
  endtask

  initial begin
    exp_t zero_e;
    zero_e = '{dout: 1'b0, dvalid: 1'b0, sof: 1'b0, busy: 1'b0, ack: '0, src: 2'd0};
    rst = 1'b1;
    set_both('0, '0);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs(0, zero_e);
    check_outputs(1, zero_e);
    rst = 1'b0;

    // single request, 0xA5 from requester 0
    set_both(4'b0001, 32'h0000_00A5);
    run_cycles(14, 0);

    // requester 2 alone moves the pointer to 3, then 0 and 2 compete
    set_both(4'b0100, 32'h0033_0000);
    run_cycles(12, 0);
    set_both(4'b0101, 32'h005A_00C3);
    run_cycles(26, 0);

    // parity patterns: three ones, then two ones
    set_both(4'b0001, 32'h0000_0007);
    run_cycles(12, 0);
    set_both(4'b0010, 32'h0000_0300);
    run_cycles(12, 0);

    // all requesters held and re-raised: round robin, back-to-back frames
    set_both(4'b1111, {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
    run_cycles(60, 1);

    // random producers
    run_cycles(600, 2);

    // asynchronous reset in the middle of a frame
    set_both(4'b1111, 32'h1234_5678);
    run_cycles(15, 1);
    #2 rst = 1'b1;
    set_both('0, '0);
    #1;
    model_reset();
    check_outputs(0, zero_e);
    check_outputs(1, zero_e);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cycles(5, 0);
    // pointer back at 0: requester 0 wins first
    set_both(4'b1111, 32'h8899_AABB);
    run_cycles(30, 1);
    set_both('0, '0);
    run_cycles(12, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
